deser_ab_ctrl: RTL and testbench

Alignment sequencer for the 80 MHz A/B demultiplexer in the deser400 receive path. It gates the demux enable, watches the demuxed 2-bit A/B streams for a fixed training word, and issues bitslip pulses to the upstream deserializer until the word boundary is found. It then reports lock, or reports failure after all phases have been tried. One instance serves each demux channel.

---
 rtl/deser_ab_ctrl_if.sv | 24 ++
 rtl/deser_ab_ctrl.sv | 146 ++++++++++++++
 tb/tb_deser_ab_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/deser_ab_ctrl_if.sv
// Control/data bundle between the A/B alignment sequencer and its channel:
// run request, PLL status, demuxed streams, and the sequencer's status outputs.
interface deser_ab_ctrl_if;
    logic       start;
    logic       pll_lock;
    logic [1:0] dinA;
    logic [1:0] dinB;
    logic       demux_en;
    logic       bitslip;
    logic       locked;
    logic       fail;
    logic [2:0] slip_count;
    logic [2:0] state_dbg;

    modport master (
        output start, pll_lock, dinA, dinB,
        input  demux_en, bitslip, locked, fail, slip_count, state_dbg
    );

    modport slave (
        input  start, pll_lock, dinA, dinB,
        output demux_en, bitslip, locked, fail, slip_count, state_dbg
    );
endinterface

// File: rtl/deser_ab_ctrl.sv
// A/B demux word-alignment sequencer: settles, checks the training word, bitslips until aligned.
// Optional macro DESER_AB_CTRL_RETRY_EN: FAIL auto-retries after RETRY_CYC cycles instead of being sticky.
module deser_ab_ctrl #(
    parameter int         SETTLE_CYC = 8,
    parameter int         MATCH_LEN  = 16,
    parameter int         MAX_SLIP   = 3,
    parameter logic [1:0] TRAIN_A    = 2'b10,
    parameter logic [1:0] TRAIN_B    = 2'b01,
    parameter int         RETRY_CYC  = 32
) (
    input  logic           clk80,
    input  logic           reset,
    deser_ab_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        WAIT   = 3'd0,
        SETTLE = 3'd1,
        CHECK  = 3'd2,
        SLIP   = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } state_t;

    // One shared down/up counter serves settle, match and retry timing.
    localparam int CNT_MAX_SM = (SETTLE_CYC > MATCH_LEN) ? SETTLE_CYC : MATCH_LEN;
    localparam int CNT_MAX    = (CNT_MAX_SM > RETRY_CYC) ? CNT_MAX_SM : RETRY_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] MATCH_LAST  = CNT_W'(MATCH_LEN - 1);
    localparam logic [2:0]       SLIP_LIMIT  = 3'(MAX_SLIP);
`ifdef DESER_AB_CTRL_RETRY_EN
    localparam logic [CNT_W-1:0] RETRY_LOAD  = CNT_W'(RETRY_CYC - 1);
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_slip_count;
    logic             r_demux_en;
    logic             r_bitslip;
    logic             r_locked;
    logic             r_fail;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_slip_next;
    logic             w_match;
    logic             w_run;

    assign w_match = (bus.dinA == TRAIN_A) && (bus.dinB == TRAIN_B);
    assign w_run   = bus.start && bus.pll_lock;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_slip_next  = r_slip_count;
        if (!w_run) begin
            w_state_next = WAIT;
        end else begin
            case (r_state)
                WAIT: begin
                    w_state_next = SETTLE;
                    w_cnt_next   = SETTLE_LOAD;
                    w_slip_next  = '0;
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        w_state_next = CHECK;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (w_match) begin
                        if (r_cnt == MATCH_LAST) begin
                            w_state_next = LOCKED;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end else if (r_slip_count < SLIP_LIMIT) begin
                        w_state_next = SLIP;
                        w_slip_next  = r_slip_count + 1'b1;
                    end else begin
                        w_state_next = FAIL;
`ifdef DESER_AB_CTRL_RETRY_EN
                        w_cnt_next   = RETRY_LOAD;
`endif
                    end
                end
                SLIP: begin
                    w_state_next = SETTLE;
                    w_cnt_next   = SETTLE_LOAD;
                end
                LOCKED: begin
                    w_state_next = LOCKED;
                end
                FAIL: begin
`ifdef DESER_AB_CTRL_RETRY_EN
                    if (r_cnt == '0) begin
                        w_state_next = SETTLE;
                        w_cnt_next   = SETTLE_LOAD;
                        w_slip_next  = '0;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
`else
                    w_state_next = FAIL;
`endif
                end
                default: begin
                    w_state_next = WAIT;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk80 or posedge reset) begin
        if (reset) begin
            r_state      <= WAIT;
            r_cnt        <= '0;
            r_slip_count <= '0;
            r_demux_en   <= 1'b0;
            r_bitslip    <= 1'b0;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_slip_count <= w_slip_next;
            r_demux_en   <= (w_state_next == SETTLE) || (w_state_next == CHECK) ||
                            (w_state_next == SLIP)   || (w_state_next == LOCKED);
            r_bitslip    <= (w_state_next == SLIP);
            r_locked     <= (w_state_next == LOCKED);
            r_fail       <= (w_state_next == FAIL);
        end
    end

    assign bus.demux_en   = r_demux_en;
    assign bus.bitslip    = r_bitslip;
    assign bus.locked     = r_locked;
    assign bus.fail       = r_fail;
    assign bus.slip_count = r_slip_count;
    assign bus.state_dbg  = r_state;
endmodule

// File: tb/tb_deser_ab_ctrl.sv
// Directed bench for deser_ab_ctrl: reset, direct lock, slip search, abort/relock,
// async reset mid-slip, and sticky fail (or auto-retry when DESER_AB_CTRL_RETRY_EN is defined).
module tb_deser_ab_ctrl;
    localparam int SETTLE_CYC = 8;

    logic clk80 = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    deser_ab_ctrl_if bus ();

    deser_ab_ctrl dut (
        .clk80 (clk80),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk80 = ~clk80;

    // Deserializer phase model: training word appears once 'need' bitslips have been seen.
    int   need = 0;
    int   slip_base = 0;
    int   slips_seen = 0;
    int   consec_seen = 0;
    int   short_gap_seen = 0;
    int   cyc = 0;
    int   last_slip = -1000;
    logic prev_slip = 1'b0;

    always @(posedge clk80) begin
        cyc = cyc + 1;
        if (bus.bitslip === 1'b1) begin
            slips_seen = slips_seen + 1;
            if (prev_slip) consec_seen = consec_seen + 1;
            if (cyc - last_slip < SETTLE_CYC + 1) short_gap_seen = short_gap_seen + 1;
            last_slip = cyc;
        end
        prev_slip = (bus.bitslip === 1'b1);
    end

    assign bus.dinA = ((slips_seen - slip_base) >= need) ? 2'b10 : 2'b01;
    assign bus.dinB = ((slips_seen - slip_base) >= need) ? 2'b01 : 2'b10;

    task automatic go_idle();
        bus.start = 1'b0;
        repeat (2) @(negedge clk80);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.pll_lock = 1'b1;
        need = 0;
        slip_base = slips_seen;
        repeat (3) @(negedge clk80);
        n_cmp++; if (bus.demux_en !== 1'b0) begin n_bad++; $display("FAIL reset.demux_en: got %b expected 0", bus.demux_en); end
        n_cmp++; if (bus.bitslip !== 1'b0) begin n_bad++; $display("FAIL reset.bitslip: got %b expected 0", bus.bitslip); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset.locked: got %b expected 0", bus.locked); end
        n_cmp++; if (bus.fail !== 1'b0) begin n_bad++; $display("FAIL reset.fail: got %b expected 0", bus.fail); end
        n_cmp++; if (bus.slip_count !== 3'd0) begin n_bad++; $display("FAIL reset.slip_count: got %0d expected 0", bus.slip_count); end
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_bad++; $display("FAIL reset.state: got %0d expected 0", bus.state_dbg); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_bad++; $display("FAIL reset.release_state: got %0d expected 0", bus.state_dbg); end
        @(negedge clk80);
        n_cmp++; if (bus.state_dbg !== 3'd1) begin n_bad++; $display("FAIL reset.first_edge_state: got %0d expected 1", bus.state_dbg); end
        n_cmp++; if (bus.demux_en !== 1'b1) begin n_bad++; $display("FAIL reset.first_edge_demux_en: got %b expected 1", bus.demux_en); end
        bus.start = 1'b0;
        @(negedge clk80);
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_bad++; $display("FAIL reset.abort_state: got %0d expected 0", bus.state_dbg); end
        n_cmp++; if (bus.demux_en !== 1'b0) begin n_bad++; $display("FAIL reset.abort_demux_en: got %b expected 0", bus.demux_en); end
        $display("test_reset: done");
    endtask

    task automatic test_lock_direct();
        int s0;
        go_idle();
        need = 0;
        slip_base = slips_seen;
        s0 = slips_seen;
        bus.start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk80);
            if (c == 1) begin
                n_cmp++; if (bus.demux_en !== 1'b1) begin n_bad++; $display("FAIL lock_direct.demux_en_c1: got %b expected 1", bus.demux_en); end
            end
            if (c == 24) begin
                n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL lock_direct.locked_c24: got %b expected 0", bus.locked); end
            end
        end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL lock_direct.locked_c25: got %b expected 1", bus.locked); end
        n_cmp++; if (bus.state_dbg !== 3'd4) begin n_bad++; $display("FAIL lock_direct.state: got %0d expected 4", bus.state_dbg); end
        n_cmp++; if (bus.slip_count !== 3'd0) begin n_bad++; $display("FAIL lock_direct.slip_count: got %0d expected 0", bus.slip_count); end
        n_cmp++; if (slips_seen - s0 !== 0) begin n_bad++; $display("FAIL lock_direct.bitslips: got %0d expected 0", slips_seen - s0); end
        $display("test_lock_direct: done");
    endtask

    task automatic test_slip_two();
        int s0, k0, g0, lock_cyc;
        go_idle();
        need = 2;
        slip_base = slips_seen;
        s0 = slips_seen;
        k0 = consec_seen;
        g0 = short_gap_seen;
        lock_cyc = -1;
        bus.start = 1'b1;
        for (int c = 1; c <= 200 && lock_cyc < 0; c++) begin
            @(negedge clk80);
            if (bus.locked === 1'b1) lock_cyc = c;
        end
        n_cmp++; if (lock_cyc !== 45) begin n_bad++; $display("FAIL slip_two.lock_cycle: got %0d expected 45", lock_cyc); end
        n_cmp++; if (slips_seen - s0 !== 2) begin n_bad++; $display("FAIL slip_two.bitslips: got %0d expected 2", slips_seen - s0); end
        n_cmp++; if (consec_seen - k0 !== 0) begin n_bad++; $display("FAIL slip_two.wide_pulse: got %0d expected 0", consec_seen - k0); end
        n_cmp++; if (short_gap_seen - g0 !== 0) begin n_bad++; $display("FAIL slip_two.short_gap: got %0d expected 0", short_gap_seen - g0); end
        n_cmp++; if (bus.slip_count !== 3'd2) begin n_bad++; $display("FAIL slip_two.slip_count: got %0d expected 2", bus.slip_count); end
        $display("test_slip_two: done, lock at cycle %0d", lock_cyc);
    endtask

    task automatic test_pll_drop();
        // Entered from LOCKED with slip_count=2.
        bus.pll_lock = 1'b0;
        @(negedge clk80);
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL pll_drop.locked: got %b expected 0", bus.locked); end
        n_cmp++; if (bus.demux_en !== 1'b0) begin n_bad++; $display("FAIL pll_drop.demux_en: got %b expected 0", bus.demux_en); end
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_bad++; $display("FAIL pll_drop.state: got %0d expected 0", bus.state_dbg); end
        bus.pll_lock = 1'b1;
        need = 0;
        slip_base = slips_seen;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk80);
            if (c == 24) begin
                n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL pll_drop.relock_c24: got %b expected 0", bus.locked); end
            end
        end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL pll_drop.relock_c25: got %b expected 1", bus.locked); end
        n_cmp++; if (bus.slip_count !== 3'd0) begin n_bad++; $display("FAIL pll_drop.slip_count: got %0d expected 0", bus.slip_count); end
        $display("test_pll_drop: done");
    endtask

    task automatic test_reset_mid_slip();
        logic found;
        go_idle();
        need = 1000;
        slip_base = slips_seen;
        found = 1'b0;
        bus.start = 1'b1;
        for (int c = 1; c <= 50 && !found; c++) begin
            @(negedge clk80);
            if (bus.bitslip === 1'b1) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL mid_slip.pulse_seen: got %b expected 1", found); end
        n_cmp++; if (bus.slip_count !== 3'd1) begin n_bad++; $display("FAIL mid_slip.slip_count: got %0d expected 1", bus.slip_count); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (bus.bitslip !== 1'b0) begin n_bad++; $display("FAIL mid_slip.async_clear: got %b expected 0", bus.bitslip); end
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_bad++; $display("FAIL mid_slip.state: got %0d expected 0", bus.state_dbg); end
        bus.start = 1'b0;
        @(negedge clk80);
        reset = 1'b0;
        repeat (3) @(negedge clk80);
        n_cmp++; if (bus.bitslip !== 1'b0) begin n_bad++; $display("FAIL mid_slip.after_release: got %b expected 0", bus.bitslip); end
        $display("test_reset_mid_slip: done");
    endtask

`ifndef DESER_AB_CTRL_RETRY_EN
    task automatic test_fail_sticky();
        int s0, fail_cyc;
        go_idle();
        need = 1000;
        slip_base = slips_seen;
        s0 = slips_seen;
        fail_cyc = -1;
        bus.start = 1'b1;
        for (int c = 1; c <= 300 && fail_cyc < 0; c++) begin
            @(negedge clk80);
            if (bus.fail === 1'b1) fail_cyc = c;
        end
        n_cmp++; if (fail_cyc !== 40) begin n_bad++; $display("FAIL fail_sticky.fail_cycle: got %0d expected 40", fail_cyc); end
        n_cmp++; if (slips_seen - s0 !== 3) begin n_bad++; $display("FAIL fail_sticky.bitslips: got %0d expected 3", slips_seen - s0); end
        n_cmp++; if (bus.slip_count !== 3'd3) begin n_bad++; $display("FAIL fail_sticky.slip_count: got %0d expected 3", bus.slip_count); end
        n_cmp++; if (bus.demux_en !== 1'b0) begin n_bad++; $display("FAIL fail_sticky.demux_en: got %b expected 0", bus.demux_en); end
        n_cmp++; if (bus.state_dbg !== 3'd5) begin n_bad++; $display("FAIL fail_sticky.state: got %0d expected 5", bus.state_dbg); end
        repeat (200) @(negedge clk80);
        n_cmp++; if (slips_seen - s0 !== 3) begin n_bad++; $display("FAIL fail_sticky.late_bitslips: got %0d expected 3", slips_seen - s0); end
        n_cmp++; if (bus.fail !== 1'b1) begin n_bad++; $display("FAIL fail_sticky.still_fail: got %b expected 1", bus.fail); end
        n_cmp++; if (bus.slip_count !== 3'd3) begin n_bad++; $display("FAIL fail_sticky.late_slip_count: got %0d expected 3", bus.slip_count); end
        $display("test_fail_sticky: done, fail at cycle %0d", fail_cyc);
    endtask
`else
    task automatic test_retry();
        int fail_cyc;
        logic found;
        go_idle();
        need = 1000;
        slip_base = slips_seen;
        fail_cyc = -1;
        bus.start = 1'b1;
        for (int c = 1; c <= 300 && fail_cyc < 0; c++) begin
            @(negedge clk80);
            if (bus.fail === 1'b1) fail_cyc = c;
        end
        n_cmp++; if (fail_cyc !== 40) begin n_bad++; $display("FAIL retry.fail_cycle: got %0d expected 40", fail_cyc); end
        for (int c = 41; c <= 72; c++) begin
            @(negedge clk80);
            if (c == 71) begin
                n_cmp++; if (bus.fail !== 1'b1) begin n_bad++; $display("FAIL retry.fail_c71: got %b expected 1", bus.fail); end
            end
        end
        n_cmp++; if (bus.fail !== 1'b0) begin n_bad++; $display("FAIL retry.fail_c72: got %b expected 0", bus.fail); end
        n_cmp++; if (bus.slip_count !== 3'd0) begin n_bad++; $display("FAIL retry.slip_count: got %0d expected 0", bus.slip_count); end
        n_cmp++; if (bus.state_dbg !== 3'd1) begin n_bad++; $display("FAIL retry.state: got %0d expected 1", bus.state_dbg); end
        found = 1'b0;
        for (int c = 1; c <= 50 && !found; c++) begin
            @(negedge clk80);
            if (bus.bitslip === 1'b1) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL retry.pulses_resume: got %b expected 1", found); end
        need = 0;
        found = 1'b0;
        for (int c = 1; c <= 200 && !found; c++) begin
            @(negedge clk80);
            if (bus.locked === 1'b1) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL retry.relock: got %b expected 1", found); end
        $display("test_retry: done, fail at cycle %0d", fail_cyc);
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.start = 1'b1;
        bus.pll_lock = 1'b1;
        test_reset();
        test_lock_direct();
        test_slip_two();
        test_pll_drop();
        test_reset_mid_slip();
`ifndef DESER_AB_CTRL_RETRY_EN
        test_fail_sticky();
`else
        test_retry();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
